// File: rtl/result_drain.sv
// result_drain: captures the 4x4 systolic array accumulations in one strobe,
// optionally requantizes them to int8, and streams them out as 64-bit beats
// over a valid/ready handshake with completion, saturation and drop flags.
module result_drain #(
    parameter int N      = 4,
    parameter int ACC_W  = 32,
    parameter int DATA_W = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_out,
    input  logic [N*N*ACC_W-1:0]    systolic_output,
    input  logic                    quant_en,
    input  logic [4:0]              shift_amt,
    input  logic                    src_ready,
    output logic                    dest_valid,
    output logic [DATA_W-1:0]       final_data_out,
    output logic                    last,
    output logic                    busy,
    output logic                    sat_flag,
    output logic                    drop_err,
    output logic                    done
);

    localparam int NUM_EL = N * N;
    localparam int BUF_W  = NUM_EL * ACC_W;
    localparam int Q_W    = NUM_EL * 8;
    localparam int BEATS  = BUF_W / DATA_W;
    localparam int QBEATS = Q_W / DATA_W;
    localparam int CNT_W  = $clog2(BEATS);

    localparam logic [CNT_W-1:0] RAW_LAST = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] QNT_LAST = CNT_W'(QBEATS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_W-1:0]       buf_q [BEATS];
    logic [DATA_W-1:0]       buf_d [BEATS];
    logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic                    mode_q, mode_d;
    logic                    sat_q, sat_d;
    logic                    done_q, done_d;
    logic                    drop_q, drop_d;

    logic [Q_W-1:0]          qvec;
    logic                    q_sat;
    logic signed [ACC_W-1:0] el;
    logic signed [ACC_W-1:0] shr;
    logic [DATA_W-1:0]       cap_beat [BEATS];
    logic [CNT_W-1:0]        final_idx;
    logic                    xfer;

    // Clamp a shifted accumulation into the signed int8 range.
    function automatic logic [7:0] sat8(input logic signed [ACC_W-1:0] v);
        if (v > 127) begin
            return 8'h7F;
        end else if (v < -128) begin
            return 8'h80;
        end else begin
            return v[7:0];
        end
    endfunction

    // True when sat8 would have to clamp this value.
    function automatic logic clamps(input logic signed [ACC_W-1:0] v);
        return (v > 127) || (v < -128);
    endfunction

    // Requantize every element to int8 (element 0 in the top byte) and collect clamp events.
    always_comb begin
        qvec  = '0;
        q_sat = 1'b0;
        el    = '0;
        shr   = '0;
        for (int i = 0; i < NUM_EL; i++) begin
            el  = systolic_output[BUF_W-1-ACC_W*i -: ACC_W];
            shr = el >>> shift_amt;
            qvec[Q_W-1-8*i -: 8] = sat8(shr);
            q_sat = q_sat | clamps(shr);
        end
    end

    // Arrange the capture as output beats so draining is a simple index by beat_cnt.
    always_comb begin
        for (int k = 0; k < BEATS; k++) begin
            cap_beat[k] = systolic_output[BUF_W-1-DATA_W*k -: DATA_W];
            if (quant_en) begin
                if (k < QBEATS) begin
                    cap_beat[k] = qvec[Q_W-1-DATA_W*(k % QBEATS) -: DATA_W];
                end else begin
                    cap_beat[k] = '0;
                end
            end
        end
    end

    // Next-state and output logic of the IDLE/SEND drain sequencer.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        beat_cnt_d = beat_cnt_q;
        mode_d     = mode_q;
        sat_d      = sat_q;
        done_d     = 1'b0;
        drop_d     = 1'b0;

        dest_valid     = (state_q == SEND);
        busy           = (state_q == SEND);
        final_idx      = mode_q ? QNT_LAST : RAW_LAST;
        last           = dest_valid && (beat_cnt_q == final_idx);
        final_data_out = dest_valid ? buf_q[beat_cnt_q] : '0;
        sat_flag       = sat_q;
        drop_err       = drop_q;
        done           = done_q;
        xfer           = dest_valid && src_ready;

        case (state_q)
            IDLE: begin
                if (load_out) begin
                    state_d    = SEND;
                    buf_d      = cap_beat;
                    mode_d     = quant_en;
                    beat_cnt_d = '0;
                    sat_d      = quant_en & q_sat;
                end
            end
            SEND: begin
                // A capture arriving while a matrix is still draining is rejected.
                if (load_out) begin
                    drop_d = 1'b1;
                end
                if (xfer) begin
                    if (beat_cnt_q == final_idx) begin
                        state_d    = IDLE;
                        beat_cnt_d = '0;
                        done_d     = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, buffer and flag registers; everything clears while reset is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            mode_q     <= 1'b0;
            sat_q      <= 1'b0;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
            for (int k = 0; k < BEATS; k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            mode_q     <= mode_d;
            sat_q      <= sat_d;
            done_q     <= done_d;
            drop_q     <= drop_d;
            buf_q      <= buf_d;
        end
    end

endmodule

// File: tb/tb_result_drain.sv
// tb_result_drain: directed scoreboard bench for result_drain.
module tb_result_drain;

    logic         clk = 1'b0;
    logic         reset;
    logic         load_out;
    logic [511:0] systolic_output;
    logic         quant_en;
    logic [4:0]   shift_amt;
    logic         src_ready;
    logic         dest_valid;
    logic [63:0]  final_data_out;
    logic         last;
    logic         busy;
    logic         sat_flag;
    logic         drop_err;
    logic         done;

    result_drain #(.N(4), .ACC_W(32), .DATA_W(64)) dut (
        .clk            (clk),
        .reset          (reset),
        .load_out       (load_out),
        .systolic_output(systolic_output),
        .quant_en       (quant_en),
        .shift_amt      (shift_amt),
        .src_ready      (src_ready),
        .dest_valid     (dest_valid),
        .final_data_out (final_data_out),
        .last           (last),
        .busy           (busy),
        .sat_flag       (sat_flag),
        .drop_err       (drop_err),
        .done           (done)
    );

    always #5 clk = ~clk;

    int           checks;
    int           failures;
    int           done_seen;
    int           xfers;
    logic [64:0]  sb [$];
    logic [31:0]  y [16];
    logic         exp_sat;
    logic         held_pending;
    logic [63:0]  held_data;
    logic         held_last;
    logic         use_pat;
    int           pi;
    logic         pat [7];
    logic         s_valid, s_busy, s_sat, s_drop, s_done;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_y();
        for (int i = 0; i < 16; i++) begin
            systolic_output[511-32*i -: 32] = y[i];
        end
    endtask

    // Push the expected beat sequence for the current y[] under the given mode.
    task automatic push_expected(input logic q, input logic [4:0] sh);
        logic [7:0]  qb [16];
        logic [63:0] d;
        int          v;
        exp_sat = 1'b0;
        if (!q) begin
            for (int k = 0; k < 8; k++) begin
                sb.push_back({(k == 7), y[2*k], y[2*k+1]});
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                v = $signed(y[i]);
                v = v >>> sh;
                if (v > 127) begin
                    qb[i] = 8'h7F;
                    exp_sat = 1'b1;
                end else if (v < -128) begin
                    qb[i] = 8'h80;
                    exp_sat = 1'b1;
                end else begin
                    qb[i] = v[7:0];
                end
            end
            for (int k = 0; k < 2; k++) begin
                d = '0;
                for (int j = 0; j < 8; j++) begin
                    d = {d[55:0], qb[8*k+j]};
                end
                sb.push_back({(k == 1), d});
            end
        end
    endtask

    // One clock: sample at the falling edge, score any transfer, then step past the rising edge.
    task automatic cycle();
        logic [64:0] e;
        @(negedge clk);
        s_valid = dest_valid;
        s_busy  = busy;
        s_sat   = sat_flag;
        s_drop  = drop_err;
        s_done  = done;
        if (done) done_seen++;
        if (!dest_valid) chk("idle_data_zero", final_data_out, 64'd0);
        if (held_pending) begin
            chk("stall_hold_data", final_data_out, held_data);
            chk("stall_hold_last", {63'd0, last}, {63'd0, held_last});
        end
        if (dest_valid && src_ready) begin
            xfers++;
            if (sb.size() == 0) begin
                chk("extra_beat", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("beat_data", final_data_out, e[63:0]);
                chk("beat_last", {63'd0, last}, {63'd0, e[64]});
            end
        end
        held_pending = dest_valid && !src_ready;
        held_data    = final_data_out;
        held_last    = last;
        @(posedge clk);
        #1;
    endtask

    task automatic drain_to(input int remain, input int budget);
        int n;
        n = 0;
        while (sb.size() > remain && n < budget) begin
            if (use_pat) begin
                src_ready = pat[pi % 7];
                pi++;
            end
            cycle();
            n++;
        end
        chk("drain_timeout", 64'(sb.size()), 64'(remain));
    endtask

    task automatic load(input logic q, input logic [4:0] sh);
        drive_y();
        quant_en  = q;
        shift_amt = sh;
        push_expected(q, sh);
        load_out  = 1'b1;
        cycle();
        load_out  = 1'b0;
    endtask

    initial begin
        int d0;
        checks = 0; failures = 0; done_seen = 0; xfers = 0;
        held_pending = 1'b0; held_data = '0; held_last = 1'b0;
        use_pat = 1'b0; pi = 0;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        reset = 1'b0; load_out = 1'b0; systolic_output = '0;
        quant_en = 1'b0; shift_amt = '0; src_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_valid", {63'd0, dest_valid}, 64'd0);
        chk("rst_data", final_data_out, 64'd0);
        chk("rst_flags", {58'd0, last, busy, sat_flag, drop_err, done, 1'b0}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        cycle();

        // 1. Raw drain, no backpressure
        for (int i = 0; i < 16; i++) y[i] = 32'(i + 1);
        load(1'b0, 5'd0);
        chk("t1_busy_after_load", {63'd0, busy}, 64'd1);
        drain_to(0, 20);
        cycle();
        chk("t1_done", {63'd0, s_done}, 64'd1);
        chk("t1_busy_low", {63'd0, s_busy}, 64'd0);
        chk("t1_sat_raw", {63'd0, s_sat}, 64'd0);
        cycle();
        chk("t1_done_once", {63'd0, s_done}, 64'd0);

        // 2. Backpressure
        for (int i = 0; i < 16; i++) y[i] = 32'hA000_0000 + 32'(i * 3);
        xfers = 0;
        load(1'b0, 5'd0);
        use_pat = 1'b1;
        drain_to(0, 60);
        use_pat = 1'b0;
        src_ready = 1'b1;
        chk("t2_xfer_count", 64'(xfers), 64'd8);
        cycle();
        chk("t2_done", {63'd0, s_done}, 64'd1);

        // 3. Requant with saturation; mode inputs change while in flight
        for (int i = 0; i < 16; i++) y[i] = 32'd0;
        y[0] = 32'h0000_0100; y[1] = 32'h7FFF_0000;
        y[2] = 32'hFFFF_F000; y[3] = 32'hFFFF_FFEF;
        load(1'b1, 5'd4);
        chk("t3_model_beat0", sb[0][63:0], 64'h107F80FE_00000000);
        quant_en = 1'b0; shift_amt = 5'd0;
        drain_to(0, 10);
        cycle();
        chk("t3_done", {63'd0, s_done}, 64'd1);
        chk("t3_sat", {63'd0, s_sat}, {63'd0, exp_sat});
        chk("t3_sat_expected", {63'd0, exp_sat}, 64'd1);

        // 4. Dropped capture mid-matrix
        for (int i = 0; i < 16; i++) y[i] = 32'h1234_0000 ^ 32'(i * 32'h0101);
        load(1'b0, 5'd0);
        drain_to(5, 20);
        for (int i = 0; i < 16; i++) y[i] = 32'hDEAD_0000 + 32'(i);
        drive_y();
        load_out = 1'b1;
        cycle();
        load_out = 1'b0;
        chk("t4_drop_not_early", {63'd0, s_drop}, 64'd0);
        cycle();
        chk("t4_drop_pulse", {63'd0, s_drop}, 64'd1);
        d0 = done_seen;
        drain_to(0, 20);
        cycle();
        cycle();
        chk("t4_drop_cleared", {63'd0, s_drop}, 64'd0);
        chk("t4_done_once", 64'(done_seen - d0), 64'd1);

        // 5. Reset mid-matrix
        for (int i = 0; i < 16; i++) y[i] = 32'h5500_0000 + 32'(i);
        load(1'b0, 5'd0);
        drain_to(2, 20);
        reset = 1'b0;
        #1;
        chk("t5_valid_async", {63'd0, dest_valid}, 64'd0);
        chk("t5_data_async", final_data_out, 64'd0);
        chk("t5_busy_async", {63'd0, busy}, 64'd0);
        sb.delete();
        held_pending = 1'b0;
        d0 = done_seen;
        cycle();
        cycle();
        chk("t5_no_done", 64'(done_seen - d0), 64'd0);
        reset = 1'b1;
        for (int i = 0; i < 16; i++) y[i] = 32'h7700_0000 + 32'(i * 5);
        load(1'b0, 5'd0);
        drain_to(0, 20);

        // 6. Back-to-back capture in the done-pulse cycle
        for (int i = 0; i < 16; i++) y[i] = 32'hBB00_0000 + 32'(i);
        drive_y();
        push_expected(1'b0, 5'd0);
        load_out = 1'b1;
        cycle();
        load_out = 1'b0;
        chk("t6_done_cycle", {63'd0, s_done}, 64'd1);
        chk("t6_no_drop_a", {63'd0, s_drop}, 64'd0);
        cycle();
        chk("t6_valid_next", {63'd0, s_valid}, 64'd1);
        chk("t6_no_drop_b", {63'd0, s_drop}, 64'd0);
        drain_to(0, 20);
        cycle();
        chk("t6_done", {63'd0, s_done}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/result_drain.md
Name: result_drain

Overview:
- Downstream stage of the 4x4 systolic MAC core.
- Captures the 16 signed 32-bit PE accumulations in one strobe, optionally requantizes them to int8, and streams them out as 64-bit beats over a valid/ready handshake.
- Signals matrix completion to the top-level controller and flags saturation and dropped captures.

Parameters:
- N, 4, array dimension; only 4 is supported.
- ACC_W, 32, PE accumulator width.
- DATA_W, 64, output beat width.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- load_out  in  1  capture strobe from the core FSM
- systolic_output  in  512  packed results: y[i] at bits [511-32*i -: 32], i = row*4+col, y[0] at the MSBs
- quant_en  in  1  1 = int8 requant mode, 0 = raw 32-bit mode; sampled at capture
- shift_amt  in  5  arithmetic right shift for requant; sampled at capture
- src_ready  in  1  downstream consumer ready
- dest_valid  out  1  beat valid
- final_data_out  out  64  beat data
- last  out  1  marks the final beat of the matrix
- busy  out  1  high while in SEND
- sat_flag  out  1  any element clamped in the current matrix
- drop_err  out  1  one-cycle pulse: capture rejected
- done  out  1  one-cycle pulse: matrix fully drained

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, buffer cleared, beat_cnt 0.
- FSM states:
  - IDLE: load_out=1 captures the data and goes to SEND.
  - SEND: on a handshake with beat_cnt==final_idx, returns to IDLE and sets done=1 for the next cycle.
- Capture (IDLE && load_out), effective at the next edge:
  - Registers the buffer, latches mode, clears beat_cnt and sat_flag.
  - sat_flag is set to the OR of this capture's clamp events.
- Latency: dest_valid rises on the cycle after load_out.
- Raw mode:
  - 8 beats, final_idx = 7.
  - beat k = {y[2k], y[2k+1]}.
- Requant mode:
  - q[i] = sat8(y[i] >>> shift_amt), arithmetic shift (rounds toward -inf).
  - sat8 clamps to the range [-128, 127].
  - Quantization is computed combinationally at capture and the bytes are stored.
  - 2 beats, final_idx = 1.
  - beat k = {q[8k], ..., q[8k+7]}, with q[8k] at bits [63:56].
- Handshake:
  - A transfer occurs when dest_valid && src_ready.
  - beat_cnt increments on each transfer.
  - final_data_out and last are held stable while dest_valid && !src_ready.
  - dest_valid never drops mid-matrix.
- last = dest_valid && (beat_cnt == final_idx).
- final_data_out is 0 whenever dest_valid = 0.
- busy = (state == SEND).
- load_out in SEND, including the cycle of the final transfer:
  - The capture is ignored; buffer, mode and beat sequence are unchanged.
  - drop_err pulses on the next cycle.
- load_out in IDLE during the done-pulse cycle is accepted normally (back-to-back matrices).
- quant_en and shift_amt changes outside the capture cycle have no effect on a matrix in flight.
- Reset asserted mid-matrix:
  - dest_valid drops asynchronously; no done pulse.
  - The next capture starts at beat 0.
- sat_flag holds its value until the next accepted capture; in raw mode it is always 0.

Test Plan:
1. Raw drain: y[i] = i+1, quant_en=0, src_ready=1, load_out pulse -> dest_valid from the next cycle for 8 cycles. beat0 = 0x00000001_00000002, beat7 = 0x0000000F_00000010. last on beat7 only. done pulses the cycle after beat7. busy low afterwards.
2. Backpressure: as test 1, with src_ready pattern 1,0,0,1,0,1,1,... -> final_data_out constant during stalls. Exactly 8 transfers, in order, none duplicated or skipped.
3. Requant: quant_en=1, shift_amt=4, with y[0]=0x00000100, y[1]=0x7FFF0000, y[2]=0xFFFFF000, y[3]=0xFFFFFFEF, y[4..15]=0 -> beat0 = 0x107F80FE_00000000, beat1 = 0, last on beat1, sat_flag=1.
4. Dropped capture: load_out with a new matrix during beat 3 of SEND -> drop_err pulses one cycle. Beats 4..7 carry the original matrix. done pulses once.
5. Reset mid-matrix: reset low after beat 5 -> all outputs 0 immediately, done never pulses. After release, load_out restarts at beat0 with the new data.
6. Back-to-back: load_out in the done-pulse cycle -> accepted, no drop_err, dest_valid high the following cycle with beat0 of the second matrix.
